// File: rtl/disp_scheduler.sv
// -----------------------------------------------------------------------------
// disp_scheduler
//
// Display scheduler for the calculator's 4-digit 7-segment display. It
// arbitrates round-robin between two requesters: A (operand entry) and
// B (result). The granted 14-bit value runs through a sequential
// shift-add-3 binary-to-BCD converter, one bit per clock. The four BCD
// digits are then time-multiplexed onto active-low anode and cathode pins.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When it is defined, digits above the most significant nonzero digit are
//   blanked. The ones digit is always shown. Overflow dashes are unaffected.
//
// Parameters
//   REFRESH_BITS   refresh counter width; digit period = 2^(REFRESH_BITS-2) clocks
//
// Ports
//   clock_100Mhz   in   system clock
//   reset          in   asynchronous, active-high reset
//   a_req/a_value  in   requester A handshake and 14-bit unsigned value
//   a_ack          out  one-cycle pulse when a_value is captured
//   b_req/b_value  in   requester B handshake and 14-bit unsigned value
//   b_ack          out  one-cycle pulse when b_value is captured
//   busy           out  high while a conversion is in progress (CONVERT, LOAD)
//   Anode_Activate out  active-low digit enables (bit 0 = ones), registered
//   disp           out  active-low segments {g,f,e,d,c,b,a}, registered
// -----------------------------------------------------------------------------
module disp_scheduler #(
  parameter int REFRESH_BITS = 20
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic        a_req,
  input  logic [13:0] a_value,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [13:0] b_value,
  output logic        b_ack,
  output logic        busy,
  output logic [3:0]  Anode_Activate,
  output logic [6:0]  disp
);

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  state_t      state;
  logic [13:0] shift_reg;
  logic [15:0] bcd;
  logic [3:0]  bit_cnt;
  logic        ovf;
  logic        last_b;      // 1 = B was granted last, so A wins a tie next
  logic [15:0] disp_bcd;
  logic        disp_ovf;
  logic [REFRESH_BITS-1:0] refresh_cnt;

  // ---------------------------------------------------------------------------
  // Arbitration and conversion datapath
  // ---------------------------------------------------------------------------
  logic        grant_a;
  logic        grant_b;
  logic [13:0] cap_value;
  logic [15:0] bcd_adj;
  logic [29:0] conv_next;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign grant_a   = a_req & (~b_req | last_b);
  assign grant_b   = b_req & ~grant_a;
  assign cap_value = grant_a ? a_value : b_value;
  assign bcd_adj   = {add3(bcd[15:12]), add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  // Bits shifted out of the top of the BCD field are dropped. Only values
  // above 9999 produce them, and those are shown as overflow anyway.
  assign conv_next = {bcd_adj, shift_reg} << 1;

  // ---------------------------------------------------------------------------
  // Control FSM. Acks and busy are registered alongside the state.
  // ---------------------------------------------------------------------------
  // NOTE: every register in a clocked block is assigned with <=, so all of
  // them update together from values sampled before the edge.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      ovf       <= 1'b0;
      last_b    <= 1'b1;
      disp_bcd  <= '0;
      disp_ovf  <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            shift_reg <= cap_value;
            bcd       <= '0;
            bit_cnt   <= '0;
            ovf       <= (cap_value > 14'd9999);
            a_ack     <= grant_a;
            b_ack     <= grant_b;
            last_b    <= grant_b;
            busy      <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd, shift_reg} <= conv_next;
          bit_cnt          <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd13) state <= LOAD;
        end
        LOAD: begin
          disp_bcd <= bcd;
          disp_ovf <= ovf;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh scan
  // ---------------------------------------------------------------------------
  logic [1:0] sel;
  logic [3:0] digit;
  logic       blank;
  logic [3:0] anode_next;
  logic [6:0] seg_next;

  assign sel = refresh_cnt[REFRESH_BITS-1 -: 2];

  // NOTE: each signal in this block gets a default first, so no path through
  // the case statements can leave it unassigned and infer a latch.
  always_comb begin
    digit      = disp_bcd[3:0];
    anode_next = 4'b1110;
    blank      = 1'b0;
    seg_next   = SEG_BLANK;
    case (sel)
      2'd0: begin digit = disp_bcd[3:0];   anode_next = 4'b1110; end
      2'd1: begin digit = disp_bcd[7:4];   anode_next = 4'b1101; end
      2'd2: begin digit = disp_bcd[11:8];  anode_next = 4'b1011; end
      2'd3: begin digit = disp_bcd[15:12]; anode_next = 4'b0111; end
      default: ;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blanked when it and every digit above it are zero.
    case (sel)
      2'd1: blank = (disp_bcd[15:4] == 12'd0);
      2'd2: blank = (disp_bcd[15:8] == 8'd0);
      2'd3: blank = (disp_bcd[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    case (digit)
      4'd0: seg_next = 7'b1000000;
      4'd1: seg_next = 7'b1111001;
      4'd2: seg_next = 7'b0100100;
      4'd3: seg_next = 7'b0110000;
      4'd4: seg_next = 7'b0011001;
      4'd5: seg_next = 7'b0010010;
      4'd6: seg_next = 7'b0000010;
      4'd7: seg_next = 7'b1111000;
      4'd8: seg_next = 7'b0000000;
      4'd9: seg_next = 7'b0010000;
      default: seg_next = SEG_BLANK;
    endcase
    if (blank)    seg_next = SEG_BLANK;
    if (disp_ovf) seg_next = SEG_DASH;
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      refresh_cnt    <= '0;
      Anode_Activate <= 4'b1111;
      disp           <= SEG_BLANK;
    end else begin
      refresh_cnt    <= refresh_cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      Anode_Activate <= anode_next;
      disp           <= seg_next;
    end
  end

endmodule

// File: tb/tb_disp_scheduler.sv
// -----------------------------------------------------------------------------
// tb_disp_scheduler
//
// Directed and randomized checks of disp_scheduler, run with a short refresh
// counter. The expected digit patterns come from decimal arithmetic on the
// requested value. The expected scan position comes from the number of clocks
// since reset release. Arbitration is modelled by a single "B went last" bit.
// -----------------------------------------------------------------------------
module tb_disp_scheduler;
  localparam int RB = 4;

  logic        clock_100Mhz = 1'b0;
  logic        reset = 1'b0;
  logic        a_req = 1'b0;
  logic        b_req = 1'b0;
  logic [13:0] a_value = '0;
  logic [13:0] b_value = '0;
  logic        a_ack, b_ack, busy;
  logic [3:0]  Anode_Activate;
  logic [6:0]  disp;

  disp_scheduler #(.REFRESH_BITS(RB)) dut (
    .clock_100Mhz   (clock_100Mhz),
    .reset          (reset),
    .a_req          (a_req),
    .a_value        (a_value),
    .a_ack          (a_ack),
    .b_req          (b_req),
    .b_value        (b_value),
    .b_ack          (b_ack),
    .busy           (busy),
    .Anode_Activate (Anode_Activate),
    .disp           (disp)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  int checks = 0;
  int fails  = 0;
  int cyc;          // clock edges since reset release
  bit last_b = 1'b1;

  always @(posedge clock_100Mhz or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int pos);
    int p = 1;
    if (v > 9999) return 7'b0111111;
    for (int i = 0; i < pos; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos > 0 && v < p) return 7'b1111111;
`endif
    return seg_of((v / p) % 10);
  endfunction

  function automatic int rnd_val();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 9999;
      2: return 10000;
      3: return 16383;
      default: return int'($urandom_range(0, 16383));
    endcase
  endfunction

  // 16 samples, starting at the current negedge. The expected digit position
  // comes from the clock count since reset release.
  task automatic scan(input int v);
    int pos;
    logic [3:0] an;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clock_100Mhz);
      pos = ((cyc - 1) % (1 << RB)) >> (RB - 2);
      an  = ~(4'b0001 << pos);
      check("anode", {28'd0, Anode_Activate}, {28'd0, an});
      check($sformatf("disp_v%0d_pos%0d", v, pos), {25'd0, disp}, {25'd0, exp_seg(v, pos)});
    end
  endtask

  task automatic chk_ack(input bit is_a);
    check("a_ack", {31'd0, a_ack}, {31'd0, is_a});
    check("b_ack", {31'd0, b_ack}, {31'd0, !is_a});
    if (is_a) a_req = 1'b0;
    else      b_req = 1'b0;
    last_b = !is_a;
  endtask

  // Starts at the negedge just after the capture edge and ends at the first
  // negedge where busy is low.
  task automatic serve(input bit is_a);
    int cnt = 1;
    chk_ack(is_a);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock_100Mhz);
      if (busy) cnt++;
      else break;
    end
    check("busy_len", cnt, 15);
  endtask

  task automatic run(input bit a_on, input bit b_on, input int av, input int bv);
    bit first_a;
    a_value = 14'(av);
    b_value = 14'(bv);
    a_req   = a_on;
    b_req   = b_on;
    first_a = a_on && (!b_on || last_b);
    @(negedge clock_100Mhz);
    serve(first_a);
    @(negedge clock_100Mhz);
    if (a_on && b_on) begin
      // The second requester is granted on the first IDLE edge. The first
      // value stays displayed while the second value converts.
      chk_ack(!first_a);
      scan(first_a ? av : bv);
      check("busy_end", {31'd0, busy}, 32'd0);
      @(negedge clock_100Mhz);
      scan(first_a ? bv : av);
    end else begin
      scan(first_a ? av : bv);
    end
  endtask

  initial begin
    bit seen;
    int pat, av, bv;

    // Reset values
    #1 reset = 1'b1;
    #1;
    check("rst_a_ack", {31'd0, a_ack}, 32'd0);
    check("rst_b_ack", {31'd0, b_ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_anode", {28'd0, Anode_Activate}, 32'hF);
    check("rst_disp", {25'd0, disp}, 32'h7F);
    repeat (3) @(negedge clock_100Mhz);
    reset = 1'b0;
    @(negedge clock_100Mhz);
    check("idle_busy", {31'd0, busy}, 32'd0);
    scan(0);

    // Directed cases: a tie after reset, round-robin, single requests, boundaries.
    run(1, 1, 42, 907);
    run(1, 1, 100, 200);
    run(1, 0, 1234, 0);
    run(0, 1, 0, 10000);
    run(0, 1, 0, 9999);
    run(1, 0, 16383, 0);
    run(1, 0, 0, 0);
    run(1, 1, 5, 8000);

    // Randomized traffic
    for (int it = 0; it < 10; it++) begin
      pat = int'($urandom_range(0, 2));
      av  = rnd_val();
      bv  = rnd_val();
      run(pat != 1, pat != 0, av, bv);
    end

    // A request raised and dropped during a conversion is never granted.
    a_value = 14'd77;
    a_req   = 1'b1;
    @(negedge clock_100Mhz);
    chk_ack(1'b1);
    repeat (3) @(negedge clock_100Mhz);
    b_value = 14'd55;
    b_req   = 1'b1;
    repeat (3) @(negedge clock_100Mhz);
    b_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock_100Mhz);
      if (!busy) break;
    end
    check("drop_busy_done", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock_100Mhz);
      if (a_ack || b_ack) seen = 1'b1;
    end
    check("dropped_req_ignored", {31'd0, seen}, 32'd0);

    // Refresh wrap: 64 idle cycles of exact scan order
    @(negedge clock_100Mhz);
    repeat (4) scan(77);

    // Reset in the middle of a conversion
    @(negedge clock_100Mhz);
    a_value = 14'd4321;
    a_req   = 1'b1;
    @(negedge clock_100Mhz);
    chk_ack(1'b1);
    repeat (5) @(negedge clock_100Mhz);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_a_ack", {31'd0, a_ack}, 32'd0);
    check("mid_rst_b_ack", {31'd0, b_ack}, 32'd0);
    check("mid_rst_anode", {28'd0, Anode_Activate}, 32'hF);
    check("mid_rst_disp", {25'd0, disp}, 32'h7F);
    last_b  = 1'b1;
    b_value = 14'd321;
    b_req   = 1'b1;
    repeat (2) @(negedge clock_100Mhz);
    reset = 1'b0;
    @(negedge clock_100Mhz);
    chk_ack(1'b0);
    scan(0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock_100Mhz);
    scan(321);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Hard stop if something above stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
